// File: rtl/wb_trace_fifo.sv
`default_nettype none
// wb_trace_fifo: buffers GRF write-back and DM store events from the core and
// replays them in program order as a valid/ready trace stream.
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grf_we,
  input  logic [31:0]   grf_pc,
  input  logic [4:0]    grf_addr,
  input  logic [31:0]   grf_wd,
  input  logic          dm_we,
  input  logic [31:0]   dm_pc,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam int RW = 97;

  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d, free, remaining;
  logic          overflow_q, overflow_d, out_valid_q, out_valid_d;
  logic [RW-1:0] head_q, head_d, grf_rec, dm_rec, rec0;
  logic          pop, grf_ok, grf_acc, dm_acc, en0, en1;
  logic [1:0]    pushes;

  assign grf_rec = {1'b0, grf_pc, 27'b0, grf_addr, grf_wd};
  assign dm_rec  = {1'b1, dm_pc, dm_addr, dm_wd};

  always_comb begin
    pop       = out_valid_q & out_ready;
    // A same-cycle pop releases its slot before the pushes are considered.
    free      = (AW+1)'(DEPTH) - count_q + {{AW{1'b0}}, pop};
    grf_ok    = grf_we && (grf_addr != 5'd0);
    grf_acc   = grf_ok && (free != '0);
    dm_acc    = dm_we && ((free - {{AW{1'b0}}, grf_acc}) != '0);
    en0       = grf_acc | dm_acc;
    en1       = grf_acc & dm_acc;
    rec0      = grf_acc ? grf_rec : dm_rec;
    pushes    = {1'b0, en0} + {1'b0, en1};
    overflow_d = overflow_q | (grf_ok & ~grf_acc) | (dm_we & ~dm_acc);
    wr_ptr_d  = wr_ptr_q + AW'(pushes);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    remaining = count_q - {{AW{1'b0}}, pop};
    count_d   = remaining + (AW+1)'(pushes);
    out_valid_d = (count_d != '0);
    head_d    = head_q;
    // When nothing older survives, the new head is the first record pushed now.
    if (count_d != '0) begin
      head_d = (remaining == '0) ? rec0 : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (en0) mem_q[wr_ptr_q] <= rec0;
    if (en1) mem_q[wr_ptr_q + AW'(1)] <= dm_rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_kind  = head_q[96];
  assign out_pc    = head_q[95:64];
  assign out_addr  = head_q[63:32];
  assign out_data  = head_q[31:0];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// tb_wb_trace_fifo: directed and randomized checks of wb_trace_fifo against a
// queue-based reference model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we, dm_we, out_ready;
  logic [31:0] grf_pc, grf_wd, dm_pc, dm_addr, dm_wd;
  logic [4:0]  grf_addr;
  logic        out_valid, out_kind, overflow;
  logic [31:0] out_pc, out_addr, out_data;
  logic [AW:0] count;

  rec_t mq[$];
  logic m_ovf;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wd(grf_wd),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    rec_t h;
    check("count", 128'(count), 128'(mq.size()));
    check("overflow", 128'(overflow), 128'(m_ovf));
    check("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      check("head", 128'({out_kind, out_pc, out_addr, out_data}), 128'(h));
    end
  endtask

  // One clock: drive at negedge, advance the model, check 1 time unit after the edge.
  task automatic cycle(input logic gwe, input logic [31:0] gpc, input logic [4:0] gaddr,
                       input logic [31:0] gwd, input logic dwe, input logic [31:0] dpc,
                       input logic [31:0] daddr, input logic [31:0] dwd, input logic rdy);
    rec_t r;
    @(negedge clk);
    grf_we = gwe; grf_pc = gpc; grf_addr = gaddr; grf_wd = gwd;
    dm_we = dwe; dm_pc = dpc; dm_addr = daddr; dm_wd = dwd; out_ready = rdy;
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (gwe && gaddr != 5'd0) begin
      r = '{kind: 1'b0, pc: gpc, addr: {27'b0, gaddr}, data: gwd};
      if (mq.size() < DEPTH) mq.push_back(r); else m_ovf = 1'b1;
    end
    if (dwe) begin
      r = '{kind: 1'b1, pc: dpc, addr: daddr, data: dwd};
      if (mq.size() < DEPTH) mq.push_back(r); else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    grf_we = 0; grf_pc = 0; grf_addr = 0; grf_wd = 0;
    dm_we = 0; dm_pc = 0; dm_addr = 0; dm_wd = 0; out_ready = 0;
    m_ovf = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_count", 128'(count), 128'(0));
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_out", 128'({out_kind, out_pc, out_addr, out_data}), 128'(0));

    // Single GRF event, consumer always ready.
    cycle(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t2_addr", 128'(out_addr), 128'(8));
    check("t2_data", 128'(out_data), 128'(32'h1234));
    idle(1'b1);
    check("t2_empty", 128'(count), 128'(0));

    // Simultaneous GRF + DM: GRF record must come out first.
    cycle(1'b1, 32'h3004, 5'd9, 32'h99, 1'b1, 32'h3008, 32'h10, 32'hAB, 1'b0);
    check("t3_count", 128'(count), 128'(2));
    check("t3_first_kind", 128'(out_kind), 128'(0));
    idle(1'b1);
    check("t3_second_kind", 128'(out_kind), 128'(1));
    idle(1'b1);

    // Writes to $zero are not traced.
    cycle(1'b1, 32'h300C, 5'd0, 32'h55, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("t4_count", 128'(count), 128'(0));

    // Nine events into a stalled 8-entry FIFO.
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 32'h4000 + 32'(4 * i), 5'(i + 1), 32'(100 + i), 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("t5_count", 128'(count), 128'(DEPTH));
    check("t5_ovf", 128'(overflow), 128'(1));
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("t5_drained", 128'(count), 128'(0));

    // Full FIFO, pop plus two events: GRF fits, DM dropped.
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h5000 + 32'(4 * i), 32'(4 * i), 32'(200 + i), 1'b0);
    cycle(1'b1, 32'h6000, 5'd3, 32'hC0FFEE, 1'b1, 32'h6004, 32'h40, 32'hDEAD, 1'b1);
    check("t6_count", 128'(count), 128'(DEPTH));

    // Asynchronous reset mid-stream.
    #1 reset = 1'b1;
    #1;
    check("t6_rst_count", 128'(count), 128'(0));
    check("t6_rst_ovf", 128'(overflow), 128'(0));
    check("t6_rst_valid", 128'(out_valid), 128'(0));
    mq.delete();
    m_ovf = 1'b0;
    #1 reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, $urandom, 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, $urandom, {$urandom_range(0, 1023), 2'b00}, $urandom,
            ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35)) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    check("final_empty", 128'(count), 128'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
